rf_dump_unit: RTL and testbench
===============================

# rf_dump_unit

Hardware register-file dump engine for the pipelined RISC-V core. It watches the committed PC and stops the CPU when the PC reaches a halt address or a cycle budget runs out. It then walks the core's debug read port (`reg_sel`/`reg_data`) and streams a PC header followed by x0..x31 over a valid/ready interface to a host link or trace sink. It sits beside `sccomp` and shares the core's clock domain.

## Interface
- `HALT_PC`, default 32'h00000310: PC value that triggers a dump.
- `MAX_CYCLES`, default 1000: IDLE-cycle budget before a forced dump. 0 disables the timeout.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `pc_i`  in  32: current PC from the CPU.
- `reg_sel`  out  5: register index driven to the core debug port. Registered.
- `reg_data`  in  32: core debug read data. Must be a combinational function of `reg_sel`.
- `halt_o`  out  1: freezes the CPU (PC/pipeline stall) while high.
- `out_valid`  out  1: stream word valid.
- `out_ready`  in  1: sink accepts the word.
- `out_data`  out  32: stream word.
- `out_tag`  out  6: word identity. 0..31 is a register index, 6'h20 is the PC header, 6'h21 is the cycle count.
- `out_last`  out  1: final word of the dump.
- `busy`  out  1: dump in progress.
- `done`  out  1: dump complete. Sticky until `rst`.
- `timeout`  out  1: the dump was caused by the budget, not by `HALT_PC`. Sticky until `rst`.

## Operation
- States: IDLE, CNT (macro only), HDR, REG, DONE.
- IDLE:
  - `cyc_cnt` (32-bit) increments every cycle and saturates at all-ones.
  - If `pc_i == HALT_PC`, trigger with cause=match.
  - Otherwise, if `MAX_CYCLES != 0` and `cyc_cnt == MAX_CYCLES-1`, trigger with cause=timeout.
- If both trigger conditions hold in the same cycle, match wins and `timeout` stays 0.
- On trigger:
  - Capture `pc_i` into `pc_cap`.
  - Set `halt_o` = 1 and `timeout` = cause.
  - `cyc_cnt` freezes.
  - Next state is CNT with the macro, HDR without it.
- CNT: `out_data` = `cyc_cnt`, `out_tag` = 6'h21.
- HDR: `out_data` = `pc_cap`, `out_tag` = 6'h20. On accept, set `reg_sel` = 0 and go to REG.
- REG:
  - `out_tag` = {1'b0, `reg_sel`}.
  - `out_data` = 0 when `reg_sel` == 0, otherwise `reg_data`.
  - On accept, `reg_sel` increments.
  - At `reg_sel` == 31, `out_last` = 1; accepting that word moves to DONE.
- Accept means `out_valid && out_ready` at a rising edge. While `out_ready` is low, `out_data`, `out_tag` and `out_last` hold stable and `out_valid` stays high.
- DONE: `done` = 1, `halt_o` stays 1, `out_valid` = 0. Only `rst` leaves DONE.
- `busy` = 1 in CNT, HDR and REG.
- `pc_i` is ignored outside IDLE.

## Timing
- Reset values: state IDLE, `cyc_cnt` 0, `reg_sel` 0, and `halt_o`, `out_valid`, `out_data`, `out_tag`, `out_last`, `busy`, `done`, `timeout` all 0.
- Trigger sampled at edge N. From N+1: `halt_o` = `busy` = `out_valid` = 1, first word presented.
- Zero-stall throughput is one word per cycle.
- Dump length is 33 words, or 34 with the macro. With `out_ready` tied high, `done` rises at N+34 (N+35 with the macro).
- `reg_data` is used in the same cycle `reg_sel` is presented; there is no added read latency.
- `rst` mid-dump at any state returns everything to the reset values on the next edge. A partial stream is abandoned with no `out_last`.
- `rst` held high blocks triggering.

## Configuration
- `RF_DUMP_CYCLE_COUNT_EN`, defined:
  - CNT state exists.
  - The first word is `cyc_cnt` (tag 6'h21), then the header and registers.
  - 34 words total.
- Not defined:
  - No CNT state.
  - The dump starts at HDR.
  - 33 words total.
  - `cyc_cnt` is still kept for the timeout.

## Test plan
- Halt match, no backpressure: load rf[i] = 32'h1000_0000+i; `pc_i` hits 32'h310 at edge 20 -> words tag 20 = 32'h310, tag 0 = 0, tag k = 32'h1000_0000+k, `out_last` on tag 31, `done` = 1 at edge 54, `timeout` = 0.
- Backpressure: `out_ready` follows the pattern 1,0,0,1 repeating -> exactly 33 accepts, no duplicated or skipped tag, data stable across stalls, `halt_o` high throughout.
- Timeout: `MAX_CYCLES` = 8, `pc_i` never equals `HALT_PC` and reads 32'h44 at edge 7 -> trigger at edge 7, header 32'h44, `timeout` = 1.
- Simultaneous: `MAX_CYCLES` = 8, `pc_i` = 32'h310 exactly at edge 7 -> `timeout` = 0, header 32'h310.
- Reset mid-dump: assert `rst` for one cycle right after tag 10 is accepted -> next cycle all outputs 0, state IDLE; a later match restarts at the header with tag 20.
- Macro on: halt at edge 20 -> first word tag 21 with data 20, then header, then 32 registers, `done` at edge 55.

Source files
------------

// File: rtl/rf_dump_unit.sv
// Register-file dump engine: halts the core on HALT_PC or after a cycle budget, then streams
// the PC header and x0..x31. Define RF_DUMP_CYCLE_COUNT_EN to prepend the cycle count word.
module rf_dump_unit #(
    parameter logic [31:0] HALT_PC    = 32'h0000_0310,
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        halt_o,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_tag,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    // state | meaning
    // IDLE  | counting cycles, watching pc_i for a halt match or budget expiry
    // CNT   | presenting the frozen cycle count (tag 6'h21)
    // HDR   | presenting the captured PC (tag 6'h20)
    // REG   | presenting x[reg_sel]; x0 always reads as zero
    // DONE  | dump complete, core stays halted until rst
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
`ifdef RF_DUMP_CYCLE_COUNT_EN
        S_CNT  = 3'd1,
`endif
        S_HDR  = 3'd2,
        S_REG  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam bit          TO_EN   = (MAX_CYCLES != 0);
    localparam logic [31:0] TO_LAST = 32'(MAX_CYCLES) - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] pc_cap_q, pc_cap_d;
    logic [4:0]  reg_sel_q, reg_sel_d;
    logic        timeout_q, timeout_d;
    logic        trig_match, trig_to;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_cnt_q <= '0;
            pc_cap_q  <= '0;
            reg_sel_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_cnt_q <= cyc_cnt_d;
            pc_cap_q  <= pc_cap_d;
            reg_sel_q <= reg_sel_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_cnt_d  = cyc_cnt_q;
        pc_cap_d   = pc_cap_q;
        reg_sel_d  = reg_sel_q;
        timeout_d  = timeout_q;
        halt_o     = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_tag    = '0;
        out_last   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        trig_match = (pc_i == HALT_PC);
        trig_to    = TO_EN && (cyc_cnt_q == TO_LAST);

        case (state_q)
            S_IDLE: begin
                // A halt match outranks the budget when both fire together.
                if (trig_match || trig_to) begin
                    pc_cap_d  = pc_i;
                    timeout_d = !trig_match;
`ifdef RF_DUMP_CYCLE_COUNT_EN
                    state_d   = S_CNT;
`else
                    state_d   = S_HDR;
`endif
                end else if (cyc_cnt_q != '1) begin
                    cyc_cnt_d = cyc_cnt_q + 32'd1;
                end
            end
`ifdef RF_DUMP_CYCLE_COUNT_EN
            S_CNT: begin
                halt_o    = 1'b1;
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = cyc_cnt_q;
                out_tag   = 6'h21;
                if (out_ready) begin
                    state_d = S_HDR;
                end
            end
`endif
            S_HDR: begin
                halt_o    = 1'b1;
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = pc_cap_q;
                out_tag   = 6'h20;
                if (out_ready) begin
                    reg_sel_d = '0;
                    state_d   = S_REG;
                end
            end
            S_REG: begin
                halt_o    = 1'b1;
                busy      = 1'b1;
                out_valid = 1'b1;
                out_tag   = {1'b0, reg_sel_q};
                out_data  = (reg_sel_q == 5'd0) ? 32'd0 : reg_data;
                out_last  = (reg_sel_q == 5'd31);
                if (out_ready) begin
                    if (reg_sel_q == 5'd31) begin
                        state_d = S_DONE;
                    end else begin
                        reg_sel_d = reg_sel_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                halt_o = 1'b1;
                done   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign reg_sel = reg_sel_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rf_dump_unit.sv
// Bench for rf_dump_unit: two instances (default budget and MAX_CYCLES=8) checked against a
// word-stream model built from the trigger edge, captured PC, register file and ready sequence.
module tb_rf_dump_unit;

`ifdef RF_DUMP_CYCLE_COUNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif
    localparam int          NW        = HAS_CNT ? 34 : 33;
    localparam logic [5:0]  FIRST_TAG = HAS_CNT ? 6'h21 : 6'h20;
    localparam logic [31:0] HALT      = 32'h0000_0310;
    localparam int          LIMIT     = 300;

    logic        clk = 1'b0;
    logic        rst_def, rst_to;
    logic [31:0] pc;
    logic        rdy;
    logic        which;
    logic [31:0] rf [32];

    logic [4:0]  sel_def, sel_to;
    logic [31:0] rd_def, rd_to, dat_def, dat_to;
    logic        halt_def, halt_to, v_def, v_to, last_def, last_to;
    logic        busy_def, busy_to, done_def, done_to, to_def, to_to;
    logic [5:0]  tag_def, tag_to;

    logic        m_halt, m_valid, m_last, m_busy, m_done, m_timeout;
    logic [31:0] m_data;
    logic [5:0]  m_tag;
    logic [4:0]  m_sel;

    logic [31:0] pc_seq [LIMIT];
    bit          rdy_seq [LIMIT];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rd_def = rf[sel_def];
    assign rd_to  = rf[sel_to];

    rf_dump_unit u_def (
        .clk(clk), .rst(rst_def), .pc_i(pc), .reg_sel(sel_def), .reg_data(rd_def),
        .halt_o(halt_def), .out_valid(v_def), .out_ready(rdy), .out_data(dat_def),
        .out_tag(tag_def), .out_last(last_def), .busy(busy_def), .done(done_def),
        .timeout(to_def)
    );

    rf_dump_unit #(.MAX_CYCLES(8)) u_to (
        .clk(clk), .rst(rst_to), .pc_i(pc), .reg_sel(sel_to), .reg_data(rd_to),
        .halt_o(halt_to), .out_valid(v_to), .out_ready(rdy), .out_data(dat_to),
        .out_tag(tag_to), .out_last(last_to), .busy(busy_to), .done(done_to),
        .timeout(to_to)
    );

    assign m_halt    = which ? halt_to : halt_def;
    assign m_valid   = which ? v_to    : v_def;
    assign m_data    = which ? dat_to  : dat_def;
    assign m_tag     = which ? tag_to  : tag_def;
    assign m_last    = which ? last_to : last_def;
    assign m_busy    = which ? busy_to : busy_def;
    assign m_done    = which ? done_to : done_def;
    assign m_timeout = which ? to_to   : to_def;
    assign m_sel     = which ? sel_to  : sel_def;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] filler(input int e);
        return 32'h28 + 32'(e) * 32'd4;
    endfunction

    // First edge on which the halt PC is seen or the budget expires.
    function automatic void model_trig(input bit w, output int n, output bit to);
        int mx;
        mx = w ? 8 : 1000;
        n  = -1;
        to = 1'b0;
        for (int e = 0; e < LIMIT; e++) begin
            if (pc_seq[e] == HALT) begin
                n = e;
                return;
            end
            if (mx != 0 && e == mx - 1) begin
                n  = e;
                to = 1'b1;
                return;
            end
        end
    endfunction

    task automatic reset_all();
        rst_def = 1'b1;
        rst_to  = 1'b1;
        pc      = '0;
        rdy     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Edge numbering: edge 0 is the first edge with rst low; "cycle k" is the interval after edge k-1.
    task automatic run_scn(input string nm, input bit w, input int n_trig, input bit exp_to,
                           input int exp_done);
        logic [5:0]  etag [34];
        logic [31:0] edat [34];
        int          eedge [34];
        int          k, t, got, trig_seen, done_cycle;
        bit          pre_ok, dump_ok, stab_ok, prev_stall;
        logic [31:0] pd;
        logic [5:0]  pt;
        logic        pl;

        k = 0;
        if (HAS_CNT) begin
            etag[k] = 6'h21;
            edat[k] = 32'(n_trig);
            k++;
        end
        etag[k] = 6'h20;
        edat[k] = pc_seq[n_trig];
        k++;
        for (int r = 0; r < 32; r++) begin
            etag[k] = 6'(r);
            edat[k] = (r == 0) ? 32'd0 : rf[r];
            k++;
        end
        t = n_trig + 1;
        for (int i = 0; i < NW; i++) begin
            while (t < LIMIT - 1 && !rdy_seq[t]) t++;
            eedge[i] = t;
            t++;
        end
        if (exp_done < 0) exp_done = t;

        which = w;
        reset_all();
        if (w) rst_to = 1'b0;
        else   rst_def = 1'b0;

        got = 0; trig_seen = -1; done_cycle = -1;
        pre_ok = 1; dump_ok = 1; stab_ok = 1; prev_stall = 0;
        pd = '0; pt = '0; pl = 1'b0;
        for (int e = 0; e < LIMIT; e++) begin
            pc  = pc_seq[e];
            rdy = rdy_seq[e];
            if (prev_stall && (!m_valid || m_data !== pd || m_tag !== pt || m_last !== pl))
                stab_ok = 0;
            prev_stall = m_valid && !rdy;
            pd = m_data; pt = m_tag; pl = m_last;
            if (m_valid && rdy) begin
                if (got < NW)
                    chk($sformatf("%s word%0d", nm, got),
                        {9'd0, 16'(e), m_last, m_tag, m_data},
                        {9'd0, 16'(eedge[got]), (got == NW - 1), etag[got], edat[got]});
                got++;
            end
            @(posedge clk);
            #1;
            if (trig_seen < 0) begin
                if (m_halt) trig_seen = e;
                else if (m_busy || m_valid || m_done || m_timeout || m_last) pre_ok = 0;
            end
            if (trig_seen >= 0 && !m_done && !(m_halt && m_busy && m_valid)) dump_ok = 0;
            if (m_done) begin
                done_cycle = e + 1;
                break;
            end
        end
        chk({nm, " trig_edge"}, 64'(trig_seen), 64'(n_trig));
        chk({nm, " pre_idle"}, 64'(pre_ok), 64'd1);
        chk({nm, " dump_flags"}, 64'(dump_ok), 64'd1);
        chk({nm, " stall_stable"}, 64'(stab_ok), 64'd1);
        chk({nm, " nwords"}, 64'(got), 64'(NW));
        chk({nm, " done_cycle"}, 64'(done_cycle), 64'(exp_done));
        chk({nm, " timeout"}, 64'(m_timeout), 64'(exp_to));
        chk({nm, " done_outs"}, {59'd0, m_halt, m_valid, m_busy, m_last, m_done},
            {59'd0, 5'b10001});
        pc  = HALT;
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk({nm, " done_sticky"}, {58'd0, m_halt, m_valid, m_busy, m_done, m_timeout, 1'b0},
            {58'd0, 1'b1, 1'b0, 1'b0, 1'b1, exp_to, 1'b0});
    endtask

    typedef struct {
        bit          w;
        int          sp_edge;
        logic [31:0] sp_pc;
        int          rmode;
        int          exp_trig;
        bit          exp_to;
        int          exp_done;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n;
        bit to;
        int e_cnt;
        bit acc10;

        tbl[0] = '{1'b0, 20, HALT, 0, 20, 1'b0, 20 + NW + 1};
        tbl[1] = '{1'b0, 20, HALT, 1, 20, 1'b0, -1};
        tbl[2] = '{1'b1, -1, 32'h0, 0, 7, 1'b1, 7 + NW + 1};
        tbl[3] = '{1'b1, 7, HALT, 0, 7, 1'b0, -1};
        tbl[4] = '{1'b1, 3, HALT, 2, 3, 1'b0, -1};
        tbl[5] = '{1'b0, 0, HALT, 0, 0, 1'b0, NW + 1};

        which = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        reset_all();
        chk("reset_outs", {15'd0, m_halt, m_valid, m_data, m_tag, m_last, m_busy, m_done,
                           m_timeout, m_sel}, 64'd0);

        for (int v = 0; v < 6; v++) begin
            for (int e = 0; e < LIMIT; e++) begin
                pc_seq[e]  = filler(e);
                rdy_seq[e] = (tbl[v].rmode == 0) ? 1'b1 :
                             (tbl[v].rmode == 1) ? ((e % 4 == 0) || (e % 4 == 3)) :
                             ($urandom_range(0, 2) != 0);
            end
            if (tbl[v].sp_edge >= 0) pc_seq[tbl[v].sp_edge] = tbl[v].sp_pc;
            run_scn($sformatf("vec%0d", v), tbl[v].w, tbl[v].exp_trig, tbl[v].exp_to,
                    tbl[v].exp_done);
        end

        for (int r = 0; r < 8; r++) begin
            bit w;
            w = 1'($urandom_range(0, 1));
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            for (int e = 0; e < LIMIT; e++) begin
                pc_seq[e]  = filler(e);
                rdy_seq[e] = ($urandom_range(0, 3) != 0);
            end
            if (w) begin
                e_cnt = $urandom_range(0, 10);
                if (e_cnt < 8) pc_seq[e_cnt] = HALT;
            end else begin
                pc_seq[$urandom_range(0, 40)] = HALT;
            end
            model_trig(w, n, to);
            run_scn($sformatf("rnd%0d", r), w, n, to, -1);
        end

        // Reset in the middle of a dump, then restart from a fresh match.
        which = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        reset_all();
        rst_def = 1'b0;
        rdy     = 1'b1;
        acc10   = 1'b0;
        for (int e = 0; e < 100 && !acc10; e++) begin
            pc    = (e == 20) ? HALT : filler(e);
            acc10 = m_valid && (m_tag == 6'd10);
            @(posedge clk);
            #1;
        end
        chk("mid_tag10_seen", 64'(acc10), 64'd1);
        rst_def = 1'b1;
        pc      = HALT;
        @(posedge clk);
        #1;
        chk("mid_reset_outs", {15'd0, m_halt, m_valid, m_data, m_tag, m_last, m_busy, m_done,
                               m_timeout, m_sel}, 64'd0);
        @(posedge clk);
        #1;
        chk("rst_blocks_trig", {62'd0, m_halt, m_valid}, 64'd0);
        rst_def = 1'b0;
        for (int e = 0; e < 5; e++) begin
            pc = filler(e);
            @(posedge clk);
            #1;
        end
        chk("restart_idle", {61'd0, m_halt, m_valid, m_busy}, 64'd0);
        pc = HALT;
        @(posedge clk);
        #1;
        chk("restart_first", {25'd0, m_valid, m_tag, m_data},
            {25'd0, 1'b1, FIRST_TAG, HAS_CNT ? 32'd5 : HALT});
`ifdef RF_DUMP_CYCLE_COUNT_EN
        @(posedge clk);
        #1;
        chk("restart_hdr", {25'd0, m_valid, m_tag, m_data}, {25'd0, 1'b1, 6'h20, HALT});
`endif
        @(posedge clk);
        #1;
        chk("restart_reg0", {25'd0, m_valid, m_tag, m_data}, {25'd0, 1'b1, 6'h00, 32'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
